// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the core's MEM stage. It accepts one load/store
//   at a time over a valid/ready handshake, waits WAIT_CYCLES of modelled
//   access latency, then presents a response that is held until the datapath
//   takes it. Storage is a word-organised RAM with per-byte-lane writes.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES  extra access cycles between accept and response (0..255)
//   BASE_ADDR    byte address of word 0 (4-byte aligned)
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder idle and able to accept
//   addr       in   32  byte address
//   MemRead    in   4   byte-lane read mask (bit i = byte i)
//   MemWrite   in   4   byte-lane write mask (bit i = byte i)
//   wdata      in   32  lane-aligned store data
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   datapath accepts the response
//   rdata      out  32  load data, unread lanes are zero
//   rsp_err    out  1   request faulted: no write, rdata = 0
//
// Build option
//   DMEM_ALIGN_CHECK_EN  when defined, the combined lane mask must be a legal
//                        byte/half/word shape and addr[1:0] must match its
//                        lowest lane; violations fault. When undefined only
//                        out-of-range addresses fault.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [3:0]  MemRead,
    input  logic [3:0]  MemWrite,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // Request captured at accept
    logic [31:0] r_addr;
    logic [3:0]  r_rd_mask;
    logic [3:0]  r_wr_mask;
    logic [31:0] r_wdata;

    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_rsp_err;

    logic [31:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_wait_done;
    logic        w_commit;
    logic [31:0] w_src_addr;
    logic [3:0]  w_src_rd;
    logic [3:0]  w_src_wr;
    logic [31:0] w_src_wdata;
    logic [31:0] w_off;
    logic        w_in_range;
    logic [AW-1:0] w_idx;
    logic        w_align_fault;
    logic        w_fault;
    logic [31:0] w_rd_bits;
    logic [31:0] w_word;

    assign w_accept    = req_valid && (r_state == S_IDLE);
    // WAIT is entered with the counter at 0 and left once it has reached
    // WAIT_CYCLES, giving the full accept-to-response latency of 1+WAIT_CYCLES.
    assign w_wait_done = (r_state == S_WAIT) && (r_cnt == 8'(WAIT_CYCLES));

    // Commit happens on the edge entering RESP. With zero wait cycles that is
    // the accept edge itself, so the live inputs are used instead of the
    // (not yet loaded) capture registers. A reset on that edge drops the access.
    assign w_commit = !reset && (w_wait_done || (w_accept && (WAIT_CYCLES == 0)));

    assign w_src_addr  = (r_state == S_IDLE) ? addr     : r_addr;
    assign w_src_rd    = (r_state == S_IDLE) ? MemRead  : r_rd_mask;
    assign w_src_wr    = (r_state == S_IDLE) ? MemWrite : r_wr_mask;
    assign w_src_wdata = (r_state == S_IDLE) ? wdata    : r_wdata;

    // Unsigned subtract: addresses below BASE_ADDR wrap to a huge offset and
    // therefore land out of range.
    assign w_off      = w_src_addr - BASE_ADDR;
    assign w_in_range = (w_off >> 2) < DEPTH;
    assign w_idx      = w_off[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    logic [3:0] w_mask;

    // Legal shapes are single bytes, aligned halves and the full word; the
    // address low bits must point at the lowest enabled lane.
    always_comb begin
        w_mask        = w_src_rd | w_src_wr;
        w_align_fault = 1'b0;
        case (w_mask)
            4'b0000: w_align_fault = 1'b0;
            4'b0001: w_align_fault = (w_src_addr[1:0] != 2'd0);
            4'b0010: w_align_fault = (w_src_addr[1:0] != 2'd1);
            4'b0100: w_align_fault = (w_src_addr[1:0] != 2'd2);
            4'b1000: w_align_fault = (w_src_addr[1:0] != 2'd3);
            4'b0011: w_align_fault = (w_src_addr[1:0] != 2'd0);
            4'b1100: w_align_fault = (w_src_addr[1:0] != 2'd2);
            4'b1111: w_align_fault = (w_src_addr[1:0] != 2'd0);
            default: w_align_fault = 1'b1;
        endcase
    end
`else
    assign w_align_fault = 1'b0;
`endif

    assign w_fault   = !w_in_range || w_align_fault;
    assign w_rd_bits = {{8{w_src_rd[3]}}, {8{w_src_rd[2]}},
                        {8{w_src_rd[1]}}, {8{w_src_rd[0]}}};
    assign w_word    = r_mem[w_idx];

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default assignment first so every path assigns and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_wait_done) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == S_IDLE);
        rsp_valid = (r_state == S_RESP);
        rdata     = r_rdata;
        rsp_err   = r_rsp_err;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_rd_mask <= '0;
            r_wr_mask <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= addr;
                r_rd_mask <= MemRead;
                r_wr_mask <= MemWrite;
                r_wdata   <= wdata;
            end

            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= '0;
            end

            // NOTE: non-blocking assignment, so on a combined read/write the
            // captured word is the value before this edge's RAM write.
            if (w_commit) begin
                r_rsp_err <= w_fault;
                r_rdata   <= w_fault ? 32'h0 : (w_word & w_rd_bits);
            end
        end
    end

    // NOTE: the RAM array is deliberately left out of reset; contents survive
    // reset and the array maps onto plain RAM macros.
    always_ff @(posedge clk) begin
        if (w_commit && !w_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (w_src_wr[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_src_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Randomised scoreboard bench for dmem_responder. A byte-level reference
//   memory computes the expected response for every issued request; a
//   separate monitor pops expectations when the DUT presents a response and
//   checks data, error flag, latency, stability under backpressure and that
//   req_ready stays low while busy.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int unsigned DEPTH       = 1024;
    localparam int unsigned WAIT_CYCLES = 2;
    localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [3:0]  MemRead;
    logic [3:0]  MemWrite;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rdata;
    logic        rsp_err;

    dmem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES),
        .BASE_ADDR   (BASE_ADDR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .addr      (addr),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rdata     (rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        longint      acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [DEPTH];
    int          stall    = 0;
    bit          have_cur = 0;
    exp_t        cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte-granular memory with read-before-write semantics.
    task automatic model_access(input logic [31:0] a, input logic [3:0] rd, input logic [3:0] wr,
                                input logic [31:0] wd, output logic [31:0] d, output logic e);
        logic [31:0] off;
        int unsigned idx;
        off = a - BASE_ADDR;
        e   = (off / 4) >= DEPTH;
`ifdef DMEM_ALIGN_CHECK_EN
        begin
            logic [3:0] m;
            int         low;
            m   = rd | wr;
            low = 0;
            for (int i = 3; i >= 0; i--) if (m[i]) low = i;
            if (m != 4'b0000) begin
                if (!(m inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}))
                    e = 1'b1;
                if (int'(a[1:0]) != low)
                    e = 1'b1;
            end
        end
`endif
        d = 32'h0;
        if (!e) begin
            idx = off / 4;
            for (int i = 0; i < 4; i++)
                if (rd[i]) d[8*i +: 8] = mdl[idx][8*i +: 8];
            for (int i = 0; i < 4; i++)
                if (wr[i]) mdl[idx][8*i +: 8] = wd[8*i +: 8];
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [31:0] a, input logic [3:0] rd, input logic [3:0] wr,
                         input logic [31:0] wd, input bit expect_rsp);
        int   t;
        exp_t x;
        t = 0;
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        addr      = a;
        MemRead   = rd;
        MemWrite  = wr;
        wdata     = wd;
        req_valid = 1'b1;
        if (expect_rsp) begin
            model_access(a, rd, wr, wd, x.d, x.e);
            x.acc = cyc + 1;
            sb.push_back(x);
        end
        @(negedge clk);
        // Scramble inputs while busy: the DUT must ignore them.
        req_valid = 1'b0;
        addr      = $urandom;
        MemRead   = 4'($urandom);
        MemWrite  = 4'($urandom);
        wdata     = $urandom;
    endtask

    // Monitor plus rsp_ready driver; rsp_ready is updated first so the
    // handshake decision matches what the DUT sees at the next edge.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (stall > 0) begin
                rsp_ready = 1'b0;
                stall--;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
            if (reset) begin
                have_cur = 0;
            end else if (rsp_valid) begin
                if (!have_cur) begin
                    have_cur = 1;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp: rsp_valid with empty scoreboard (cycle %0d)", cyc);
                        cur.d   = rdata;
                        cur.e   = rsp_err;
                        cur.acc = cyc - 1 - WAIT_CYCLES;
                    end else begin
                        cur = sb.pop_front();
                        check("latency", 32'(cyc - cur.acc), 32'(1 + WAIT_CYCLES));
                    end
                end
                check("rdata", rdata, cur.d);
                check("rsp_err", 32'(rsp_err), 32'(cur.e));
                check("req_ready_busy", 32'(req_ready), 32'd0);
                if (rsp_ready) have_cur = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic [3:0]  shapes [7];
        int          t;

        shapes = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

        reset     = 1'b1;
        req_valid = 1'b0;
        addr      = '0;
        MemRead   = '0;
        MemWrite  = '0;
        wdata     = '0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Prefill every word so all later loads are fully defined.
        for (int i = 0; i < int'(DEPTH); i++)
            issue(BASE_ADDR + 32'(4 * i), 4'b0000, 4'b1111, $urandom, 1);

        // Store then load
        issue(BASE_ADDR + 32'h10, 4'b0000, 4'b1111, 32'hDEAD_BEEF, 1);
        issue(BASE_ADDR + 32'h10, 4'b1111, 4'b0000, 32'h0, 1);

        // Byte store into lane 2, then word and byte loads
        issue(BASE_ADDR + 32'h12, 4'b0000, 4'b0100, 32'h00AB_0000, 1);
        issue(BASE_ADDR + 32'h10, 4'b1111, 4'b0000, 32'h0, 1);
        issue(BASE_ADDR + 32'h12, 4'b0100, 4'b0000, 32'h0, 1);

        // Backpressure: rsp_ready held low across the whole response window
        stall = 10;
        issue(BASE_ADDR + 32'h10, 4'b1111, 4'b0000, 32'h0, 1);

        // Range: one past the end, and a wrapped huge address
        issue(BASE_ADDR + 32'(4 * DEPTH), 4'b1111, 4'b0000, 32'h0, 1);
        issue(BASE_ADDR + 32'(4 * DEPTH), 4'b0000, 4'b1111, 32'hCAFE_F00D, 1);
        issue(BASE_ADDR - 32'h4, 4'b1111, 4'b1111, 32'h5555_AAAA, 1);

        // Empty masks and combined read/write (read returns pre-write data)
        issue(BASE_ADDR + 32'h30, 4'b0000, 4'b0000, 32'hFFFF_FFFF, 1);
        issue(BASE_ADDR + 32'h30, 4'b1111, 4'b1111, 32'h0BAD_F00D, 1);
        issue(BASE_ADDR + 32'h30, 4'b1111, 4'b0000, 32'h0, 1);

        // Misaligned word load
        issue(BASE_ADDR + 32'h11, 4'b1111, 4'b0000, 32'h0, 1);

        // Reset while in WAIT: the store must be discarded
        issue(BASE_ADDR + 32'h20, 4'b0000, 4'b1111, 32'h1234_5678, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_wait_req_ready", 32'(req_ready), 32'd1);
        check("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_wait_rdata", rdata, 32'h0);
        check("rst_wait_rsp_err", 32'(rsp_err), 32'd0);
        issue(BASE_ADDR + 32'h20, 4'b1111, 4'b0000, 32'h0, 1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       a = BASE_ADDR + 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
                1:       a = BASE_ADDR - 32'($urandom_range(1, 64));
                default: a = BASE_ADDR + 32'($urandom_range(0, 4 * DEPTH - 1));
            endcase
            if ($urandom_range(0, 1) == 0) begin
                rd = shapes[$urandom_range(0, 6)];
                a  = {a[31:2], 2'b00};
                for (int i = 3; i >= 0; i--) if (rd[i]) a[1:0] = 2'(i);
                wr = ($urandom_range(0, 1) == 0) ? 4'b0000 : rd;
                if ($urandom_range(0, 1) == 0) begin
                    wr = rd;
                    rd = 4'b0000;
                end
            end else begin
                rd = 4'($urandom);
                wr = 4'($urandom);
            end
            issue(a, rd, wr, $urandom, 1);
        end

        // Full readback catches stray writes anywhere in the array
        for (int i = 0; i < int'(DEPTH); i++)
            issue(BASE_ADDR + 32'(4 * i), 4'b1111, 4'b0000, 32'h0, 1);

        t = 0;
        while ((sb.size() != 0 || have_cur) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_outstanding", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
